// File: rtl/ame_num_divide_seq.sv
`default_nettype none
// ============================================================================
// Module      : ame_num_divide_seq
// Description : Sequential signed fixed-point divider for the affine ME
//               parameter solver. Forms N = M*D - L*C and returns
//               Q = (N << FRAC_BITS) / E, saturated to COMP_DATA_BITS signed.
//               Restoring radix-2 core, fixed latency, one job in flight.
//               Optional build macro: AME_DIV_ROUND_EN (round half away
//               from zero; truncation toward zero when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module ame_num_divide_seq #(
  parameter int COMP_DATA_BITS = 64,
  parameter int FRAC_BITS      = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           comp_init_i,
  input  logic [3:0][COMP_DATA_BITS-1:0] comp_data_i,
  input  logic [COMP_DATA_BITS-1:0]      comp_den_i,
  output logic                           comp_busy_o,
  output logic                           comp_done_o,
  output logic                           comp_dz_o,
  output logic [COMP_DATA_BITS-1:0]      comp_data_o
);

  localparam int W     = COMP_DATA_BITS;
  localparam int NB    = W + 1 + FRAC_BITS;   // quotient bits / DIV cycles
  localparam int CNT_W = $clog2(NB);

  localparam logic [W:0]       ONE_W1      = {{W{1'b0}}, 1'b1};
  localparam logic [W-1:0]     RES_MAX     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     RES_MIN     = {1'b1, {(W-1){1'b0}}};
  // Magnitude limits before negation: 2^(W-1)-1 positive, 2^(W-1) negative.
  localparam logic [NB:0]      MAG_POS_LIM = {{(NB-W+1){1'b0}}, 1'b0, {(W-1){1'b1}}};
  localparam logic [NB:0]      MAG_NEG_LIM = {{(NB-W+1){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(NB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      opm_q, opm_d, opd_q, opd_d, opl_q, opl_d, opc_q, opc_d;
  logic [W-1:0]      den_q, den_d;
  logic [NB-1:0]     dvd_q, dvd_d;      // dividend shifting out, quotient shifting in
  logic [W:0]        rem_q, rem_d;
  logic [W:0]        dvsr_q, dvsr_d;    // |E|
  logic              neg_q, neg_d;      // result sign
  logic              nneg_q, nneg_d;    // sign of N, selects dz saturation polarity
  logic              dz_q, dz_d;
  logic              done_q, done_d;
  logic              dzo_q, dzo_d;
  logic [W-1:0]      data_q, data_d;

  // Numerator and magnitudes; only low W bits of each product are kept (mod 2^W).
  logic [W-1:0]  prod_md, prod_lc, num;
  logic [W:0]    num_ext, num_abs, den_ext, den_abs;
  logic [NB-1:0] dvd_init;

  assign prod_md  = opm_q * opd_q;
  assign prod_lc  = opl_q * opc_q;
  assign num      = prod_md - prod_lc;
  assign num_ext  = {num[W-1], num};
  assign num_abs  = num[W-1] ? (~num_ext + ONE_W1) : num_ext;
  assign den_ext  = {den_q[W-1], den_q};
  assign den_abs  = den_q[W-1] ? (~den_ext + ONE_W1) : den_ext;
  assign dvd_init = NB'(num_abs) << FRAC_BITS;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  logic [W+1:0] trial;
  logic         fits;
  logic [W:0]   rem_step;

  assign trial    = {rem_q, dvd_q[NB-1]};
  assign fits     = (trial >= {1'b0, dvsr_q});
  assign rem_step = fits ? (trial[W:0] - dvsr_q) : trial[W:0];

  // Final magnitude, optionally rounded half away from zero.
  logic [NB:0] mag;
`ifdef AME_DIV_ROUND_EN
  logic round_up;
  assign round_up = ({rem_q, 1'b0} >= {1'b0, dvsr_q});
  assign mag      = {1'b0, dvd_q} + {{NB{1'b0}}, round_up};
`else
  assign mag      = {1'b0, dvd_q};
`endif

  // Sign application, saturation and divide-by-zero override of the result.
  logic [W-1:0] res;
  always_comb begin
    res = mag[W-1:0];
    if (dz_q) begin
      res = nneg_q ? RES_MIN : RES_MAX;
    end else if (neg_q) begin
      res = (mag > MAG_NEG_LIM) ? RES_MIN : (-mag[W-1:0]);
    end else if (mag > MAG_POS_LIM) begin
      res = RES_MAX;
    end
  end

  // Next-state and datapath control for IDLE -> PREP -> DIV -> FIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opm_d   = opm_q;
    opd_d   = opd_q;
    opl_d   = opl_q;
    opc_d   = opc_q;
    den_d   = den_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    neg_d   = neg_q;
    nneg_d  = nneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    dzo_d   = 1'b0;
    data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (comp_init_i) begin
          opm_d   = comp_data_i[3];
          opd_d   = comp_data_i[2];
          opl_d   = comp_data_i[1];
          opc_d   = comp_data_i[0];
          den_d   = comp_den_i;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        dvd_d   = dvd_init;
        rem_d   = '0;
        dvsr_d  = den_abs;
        neg_d   = num[W-1] ^ den_q[W-1];
        nneg_d  = num[W-1];
        dz_d    = (den_q == '0);
        cnt_d   = CNT_LOAD;
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = rem_step;
        dvd_d = {dvd_q[NB-2:0], fits};
        if (cnt_q == '0) begin
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        dzo_d   = dz_q;
        data_d  = res;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opm_q   <= '0;
      opd_q   <= '0;
      opl_q   <= '0;
      opc_q   <= '0;
      den_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      neg_q   <= 1'b0;
      nneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opm_q   <= opm_d;
      opd_q   <= opd_d;
      opl_q   <= opl_d;
      opc_q   <= opc_d;
      den_q   <= den_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      neg_q   <= neg_d;
      nneg_q  <= nneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      dzo_q   <= dzo_d;
      data_q  <= data_d;
    end
  end

  assign comp_busy_o = (state_q != S_IDLE);
  assign comp_done_o = done_q;
  assign comp_dz_o   = dzo_q;
  assign comp_data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_ame_num_divide_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ame_num_divide_seq
// Description : Directed self-checking bench for ame_num_divide_seq at
//               W=16, FRAC_BITS=4 (23-edge latency). Expected rounding
//               results follow the AME_DIV_ROUND_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ame_num_divide_seq;

  localparam int W   = 16;
  localparam int FB  = 4;
  localparam int LAT = W + 1 + FB + 2;

  logic              clk;
  logic              rst_n;
  logic              init;
  logic [3:0][W-1:0] data_in;
  logic [W-1:0]      den;
  logic              busy;
  logic              done;
  logic              dz;
  logic [W-1:0]      q;

  int checks = 0;
  int errors = 0;

  ame_num_divide_seq #(
    .COMP_DATA_BITS (W),
    .FRAC_BITS      (FB)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .comp_init_i (init),
    .comp_data_i (data_in),
    .comp_den_i  (den),
    .comp_busy_o (busy),
    .comp_done_o (done),
    .comp_dz_o   (dz),
    .comp_data_o (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Called #1 after a rising edge. Presents a job, follows it to done, and
  // checks latency, busy, result and dz. Returns while in the done cycle.
  // glitch_at >= 0 raises a second (ignored) init that many cycles in.
  task automatic run_job(input string tag,
                         input logic [W-1:0] m, input logic [W-1:0] d,
                         input logic [W-1:0] l, input logic [W-1:0] c,
                         input logic [W-1:0] e,
                         input logic [W-1:0] exp_q, input logic exp_dz,
                         input int glitch_at);
    int   lat;
    logic busy_ok;
    data_in = {m, d, l, c};
    den     = e;
    init    = 1'b1;
    @(posedge clk); #1;
    init    = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == glitch_at) begin
        init    = 1'b1;
        data_in = {16'd7, 16'd7, 16'd0, 16'd0};
        den     = 16'd1;
      end else begin
        init = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    init = 1'b0;
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " busy during job"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    chk({tag, " result"}, {16'd0, q}, {16'd0, exp_q});
    chk({tag, " dz"}, {31'd0, dz}, {31'd0, exp_dz});
  endtask

  // Outputs must return to zero in the cycle after the strobe.
  task automatic check_idle(input string tag);
    @(posedge clk); #1;
    chk({tag, " outputs cleared"}, {14'd0, busy, done, dz, q}, 32'd0);
  endtask

  // No done strobe may appear for n cycles.
  task automatic no_done(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk({tag, " no done"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    init    = 1'b0;
    data_in = '0;
    den     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {14'd0, busy, done, dz, q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset idle", {14'd0, busy, done, dz, q}, 32'd0);

    // Basic: N=10, E=4 -> 160/4 = 40
    run_job("basic", 16'd3, 16'd4, 16'd1, 16'd2, 16'd4, 16'h0028, 1'b0, -1);
    check_idle("basic");

    // Back-to-back: N=-7/E=2 -> -56, then init in done cycle: N=-7/E=-2 -> 56
    run_job("neg", 16'd1, 16'd1, 16'd2, 16'd4, 16'd2, 16'hFFC8, 1'b0, -1);
    run_job("b2b negden", 16'd1, 16'd1, 16'd2, 16'd4, 16'hFFFE, 16'h0038, 1'b0, -1);
    check_idle("b2b");

    // Rounding cases
`ifdef AME_DIV_ROUND_EN
    run_job("rnd N1E32", 16'd1, 16'd1, 16'd0, 16'd0, 16'd32, 16'h0001, 1'b0, -1);
    run_job("rnd Nm1E32", 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd32, 16'hFFFF, 1'b0, -1);
`else
    run_job("rnd N1E32", 16'd1, 16'd1, 16'd0, 16'd0, 16'd32, 16'h0000, 1'b0, -1);
    run_job("rnd Nm1E32", 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd32, 16'h0000, 1'b0, -1);
`endif
    run_job("rnd N1E3", 16'd1, 16'd1, 16'd0, 16'd0, 16'd3, 16'h0005, 1'b0, -1);

    // Saturation and divide-by-zero
    run_job("sat pos", 16'd30000, 16'd1, 16'd0, 16'd0, 16'd1, 16'h7FFF, 1'b0, -1);
    run_job("sat neg", 16'd30000, 16'd1, 16'd0, 16'd0, 16'hFFFF, 16'h8000, 1'b0, -1);
    run_job("dz neg", 16'hFFFB, 16'd1, 16'd0, 16'd0, 16'd0, 16'h8000, 1'b1, -1);
    run_job("minneg/-1", 16'h8000, 16'd1, 16'd0, 16'd0, 16'hFFFF, 16'h7FFF, 1'b0, -1);
    run_job("exact min", 16'hF800, 16'd1, 16'd0, 16'd0, 16'd1, 16'h8000, 1'b0, -1);
    run_job("just over max", 16'h0800, 16'd1, 16'd0, 16'd0, 16'd1, 16'h7FFF, 1'b0, -1);
    run_job("zero N", 16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'h0000, 1'b0, -1);
    run_job("zero N dz", 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'h7FFF, 1'b1, -1);
    check_idle("dz");

    // Second init while busy is dropped
    run_job("busy init", 16'd3, 16'd4, 16'd1, 16'd2, 16'd4, 16'h0028, 1'b0, 5);
    no_done("busy init", 30);

    // Reset in the middle of DIV
    data_in = {16'd30000, 16'd1, 16'd0, 16'd0};
    den     = 16'd7;
    init    = 1'b1;
    @(posedge clk); #1;
    init    = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", {14'd0, busy, done, dz, q}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    no_done("after abort", 30);
    run_job("after reset", 16'd3, 16'd4, 16'd1, 16'd2, 16'd4, 16'h0028, 1'b0, -1);
    check_idle("after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
